// File: rtl/mem_bist_pkg.sv
// Shared encodings for the memory BIST: controller states, pattern modes
// and the fill bits used by the checkerboard pattern.
package mem_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_INC  = 2'd0;
    localparam logic [1:0] MODE_CHK  = 2'd1;
    localparam logic [1:0] MODE_ADDR = 2'd2;
    localparam logic [1:0] MODE_DUMP = 2'd3;

    // Checkerboard word fill: every bit takes the value i[0] ^ seed[0],
    // so consecutive words alternate between all-zeros and all-ones.
    localparam logic CHK_FILL_LO = 1'b0;
    localparam logic CHK_FILL_HI = 1'b1;

endpackage

// File: rtl/mem_bist_patgen.sv
// Combinational pattern generator: expected word P(i) for a given mode and seed.
module mem_bist_patgen
    import mem_bist_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IW     = 7
) (
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [IW-1:0]     i,
    output logic [DATA_W-1:0] p
);

    logic w_chk_hi;

    assign w_chk_hi = i[0] ^ seed[0];

    // Select the pattern word; the dump mode has no pattern and yields zero.
    always_comb begin
        p = '0;
        case (mode)
            MODE_INC:  p = seed + DATA_W'(i);
            MODE_CHK:  p = {DATA_W{w_chk_hi ? CHK_FILL_HI : CHK_FILL_LO}};
            MODE_ADDR: p = DATA_W'(i);
            default:   p = '0;
        endcase
    end

endmodule

// File: rtl/mem_bist.sv
// Memory BIST controller: writes a pattern over DEPTH words, reads it back
// one word per cycle, counts mismatches, records the first one and folds
// every read word into a rotate-XOR signature.
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 128,
    parameter int  CNT_W  = 16,
    localparam int IW     = $clog2(DEPTH),
    localparam int AW     = IW + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic [AW-1:0]     mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [AW-1:0]     fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic [CNT_W-1:0]  err_count,
    output logic [DATA_W-1:0] signature
);

    state_t              r_state;
    state_t              w_next;
    logic [IW-1:0]       r_idx;
    logic [1:0]          r_mode;
    logic [DATA_W-1:0]   r_seed;
    logic [CNT_W-1:0]    r_err;
    logic [DATA_W-1:0]   r_sig;
    logic                r_pass;
    logic [AW-1:0]       r_fail_addr;
    logic [DATA_W-1:0]   r_fail_exp;
    logic [DATA_W-1:0]   r_fail_got;
    logic [DATA_W-1:0]   w_pat;
    logic                w_last;
    logic                w_accept;
    logic                w_rd_cyc;
    logic                w_mis;

    mem_bist_patgen #(
        .DATA_W (DATA_W),
        .IW     (IW)
    ) u_patgen (
        .mode (r_mode),
        .seed (r_seed),
        .i    (r_idx),
        .p    (w_pat)
    );

    // DEPTH is a power of two, so the last index is the all-ones value and
    // the index counter wraps to zero on its own at each phase change.
    assign w_last   = &r_idx;
    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_rd_cyc = (r_state == ST_READ);
    assign w_mis    = w_rd_cyc && (r_mode != MODE_DUMP) && (mem_rd != w_pat);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and per-cycle memory/handshake outputs.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        mem_we = 1'b0;
        mem_wd = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = (mode == MODE_DUMP) ? ST_READ : ST_WRITE;
            end
            ST_WRITE: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                mem_wd = w_pat;
                if (w_last) w_next = ST_READ;
            end
            ST_READ: begin
                busy = 1'b1;
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Run configuration is latched once at acceptance; index advances per word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_mode <= MODE_INC;
            r_seed <= '0;
        end else if (w_accept) begin
            r_idx  <= '0;
            r_mode <= mode;
            r_seed <= seed;
        end else if (busy) begin
            r_idx  <= r_idx + IW'(1);
        end
    end

    // Result tracking: signature, saturating error count, first-failure capture, pass.
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_err       <= '0;
            r_sig       <= '0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_got  <= '0;
        end else begin
            if (w_rd_cyc) r_sig <= {r_sig[DATA_W-2:0], r_sig[DATA_W-1]} ^ mem_rd;
            if (w_mis) begin
                // A zero count means no mismatch has been seen yet this run.
                if (r_err == '0) begin
                    r_fail_addr <= {r_idx, 2'b00};
                    r_fail_exp  <= w_pat;
                    r_fail_got  <= mem_rd;
                end
                if (r_err != '1) r_err <= r_err + CNT_W'(1);
            end
            if (w_rd_cyc && w_last) r_pass <= (r_err == '0) && !w_mis;
        end
    end

    assign mem_a     = {r_idx, 2'b00};
    assign pass      = r_pass;
    assign fail_addr = r_fail_addr;
    assign fail_exp  = r_fail_exp;
    assign fail_got  = r_fail_got;
    assign err_count = r_err;
    assign signature = r_sig;

endmodule

// File: tb/tb_mem_bist.sv
// Self-checking bench for mem_bist: two instances (16-bit and 4-bit error
// counters) each drive their own memory model with identical faults; a
// behavioural reference derives every expected output per cycle.
module tb_mem_bist;

    localparam int DEPTH  = 128;
    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [1:0]  mode;
    logic [31:0] seed;

    logic [8:0]  a1, fa1, a2, fa2;
    logic        we1, busy1, done1, pass1, we2, busy2, done2, pass2;
    logic [31:0] wd1, rd1, fe1, fg1, sig1, wd2, rd2, fe2, fg2, sig2;
    logic [15:0] ec1;
    logic [3:0]  ec2;

    // memory environment
    logic [31:0] memA [DEPTH];
    logic [31:0] memB [DEPTH];
    logic [31:0] pre_mem [DEPTH];
    logic        pre_go = 1'b0;
    logic        drop = 1'b0;
    logic        st_en = 1'b0;
    logic [6:0]  st_w = '0;
    logic [31:0] st_m = '0;

    // reference model state
    int          t = 0;
    int          len = 0;
    logic [1:0]  m_mode = '0;
    logic [31:0] m_seed = '0;
    logic [31:0] model_mem [DEPTH];
    int          raw = 0;
    logic [31:0] e_sig = '0, e_fe = '0, e_fg = '0;
    int          e_fa = 0;
    logic        e_pass = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic        cmp_en = 1'b0;
    logic [31:0] wq[$];
    logic [8:0]  aq[$];

    always #5 clk = ~clk;

    mem_bist #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
        .mem_a(a1), .mem_we(we1), .mem_wd(wd1), .mem_rd(rd1),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_addr(fa1), .fail_exp(fe1), .fail_got(fg1),
        .err_count(ec1), .signature(sig1));

    mem_bist #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
        .mem_a(a2), .mem_we(we2), .mem_wd(wd2), .mem_rd(rd2),
        .busy(busy2), .done(done2), .pass(pass2),
        .fail_addr(fa2), .fail_exp(fe2), .fail_got(fg2),
        .err_count(ec2), .signature(sig2));

    assign rd1 = drop ? 32'hFFFF_FFFF : (memA[a1[8:2]] | ((st_en && a1[8:2] == st_w) ? st_m : 32'h0));
    assign rd2 = drop ? 32'hFFFF_FFFF : (memB[a2[8:2]] | ((st_en && a2[8:2] == st_w) ? st_m : 32'h0));

    always @(posedge clk) begin
        if (pre_go) begin
            for (int k = 0; k < DEPTH; k++) begin
                memA[k] <= pre_mem[k];
                memB[k] <= pre_mem[k];
            end
        end else begin
            if (we1 && !drop) memA[a1[8:2]] <= wd1;
            if (we2 && !drop) memB[a2[8:2]] <= wd2;
        end
    end

    function automatic logic [31:0] pat(input logic [1:0] m, input logic [31:0] s, input int i);
        case (m)
            2'd0:    return s + 32'(i);
            2'd1:    return (((i % 2) == 1) != s[0]) ? 32'hFFFF_FFFF : 32'h0;
            2'd2:    return 32'(i);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mrd(input int j);
        if (drop) return 32'hFFFF_FFFF;
        return model_mem[j] | ((st_en && j == int'(st_w)) ? st_m : 32'h0);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Reference model: advances on each rising edge from the run schedule.
    initial begin
        int          j;
        logic [31:0] rdv;
        forever begin
            @(posedge clk);
            if (pre_go) for (int k = 0; k < DEPTH; k++) model_mem[k] = pre_mem[k];
            if (t >= 1 && t <= DEPTH && m_mode != 2'd3 && !drop)
                model_mem[t-1] = pat(m_mode, m_seed, t - 1);
            if (rst) begin
                t = 0; raw = 0; e_sig = 0; e_fa = 0; e_fe = 0; e_fg = 0; e_pass = 0;
            end else if (t == 0) begin
                if (start) begin
                    m_mode = mode; m_seed = seed;
                    len = (mode == 2'd3) ? DEPTH : 2 * DEPTH;
                    raw = 0; e_sig = 0; e_fa = 0; e_fe = 0; e_fg = 0; e_pass = 0;
                    t = 1;
                end
            end else begin
                if (t <= len && !(m_mode != 2'd3 && t <= DEPTH)) begin
                    j = (m_mode == 2'd3) ? t - 1 : t - 1 - DEPTH;
                    rdv = mrd(j);
                    e_sig = {e_sig[30:0], e_sig[31]} ^ rdv;
                    if (m_mode != 2'd3 && rdv != pat(m_mode, m_seed, j)) begin
                        if (raw == 0) begin
                            e_fa = 4 * j; e_fe = pat(m_mode, m_seed, j); e_fg = rdv;
                        end
                        raw++;
                    end
                    if (t == len) e_pass = (raw == 0);
                end
                t = (t == len + 1) ? 0 : t + 1;
            end
        end
    end

    task automatic cmp_dut(input string tag, input logic [8:0] a, input logic we, input logic [31:0] wd,
                           input logic bsy, input logic dn, input logic ps, input logic [8:0] fa,
                           input logic [31:0] fe, input logic [31:0] fg, input logic [15:0] ec,
                           input logic [31:0] sg, input int cap);
        int ix;
        bit wr, rdc;
        wr  = (t >= 1) && (t <= DEPTH) && (m_mode != 2'd3);
        rdc = (t >= 1) && (t <= len) && !wr;
        ix  = wr ? t - 1 : (rdc ? ((m_mode == 2'd3) ? t - 1 : t - 1 - DEPTH) : 0);
        chk({tag, ".busy"}, 64'(bsy), 64'((t >= 1) && (t <= len)));
        chk({tag, ".done"}, 64'(dn), 64'((t >= 1) && (t == len + 1)));
        chk({tag, ".we"}, 64'(we), 64'(wr));
        chk({tag, ".a"}, 64'(a), 64'(4 * ix));
        chk({tag, ".wd"}, 64'(wd), 64'(wr ? pat(m_mode, m_seed, ix) : 32'h0));
        chk({tag, ".err"}, 64'(ec), 64'((raw > cap) ? cap : raw));
        chk({tag, ".sig"}, 64'(sg), 64'(e_sig));
        chk({tag, ".pass"}, 64'(ps), 64'(e_pass));
        chk({tag, ".fa"}, 64'(fa), 64'(e_fa));
        chk({tag, ".fe"}, 64'(fe), 64'(e_fe));
        chk({tag, ".fg"}, 64'(fg), 64'(e_fg));
    endtask

    // Per-cycle comparison against the model, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                cmp_dut("d16", a1, we1, wd1, busy1, done1, pass1, fa1, fe1, fg1, ec1, sig1, 65535);
                cmp_dut("d4", a2, we2, wd2, busy2, done2, pass2, fa2, fe2, fg2, {12'h0, ec2}, sig2, 15);
            end
        end
    end

    task automatic start_run(input logic [1:0] m, input logic [31:0] s);
        @(posedge clk); #1;
        start = 1'b1; mode = m; seed = s;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int pulse_at, output int cyc);
        cyc = 1;
        wq.delete();
        aq.delete();
        while (!done1 && cyc < 600) begin
            if (we1) begin wq.push_back(wd1); aq.push_back(a1); end
            start = (cyc == pulse_at);
            mode  = 2'($urandom);
            seed  = $urandom;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!done1) chk("timeout", 64'(done1), 64'(1));
    endtask

    task automatic preload(input bit rnd);
        for (int k = 0; k < DEPTH; k++) pre_mem[k] = rnd ? $urandom : 32'h0;
        @(posedge clk); #1; pre_go = 1'b1;
        @(posedge clk); #1; pre_go = 1'b0;
    endtask

    initial begin
        int cyc;
        int m;
        rst = 1'b1; start = 1'b0; mode = '0; seed = '0;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 64'(busy1), 64'(0));
        chk("rst.err", 64'(ec1), 64'(0));
        chk("rst.a", 64'(a1), 64'(0));
        rst = 1'b0;

        // incrementing pattern from zero on a clean memory
        start_run(2'd0, 32'h0);
        wait_done(0, cyc);
        chk("inc.cycles", 64'(cyc), 64'(257));
        chk("inc.nwrites", 64'(wq.size()), 64'(128));
        if (wq.size() == 128) begin
            chk("inc.wd0", 64'(wq[0]), 64'(0));
            chk("inc.wd127", 64'(wq[127]), 64'(127));
            chk("inc.a0", 64'(aq[0]), 64'(0));
            chk("inc.a127", 64'(aq[127]), 64'(508));
        end
        chk("inc.pass", 64'(pass1), 64'(1));
        chk("inc.err", 64'(ec1), 64'(0));

        // address pattern with bit 3 stuck high in word 37
        st_en = 1'b1; st_w = 7'd37; st_m = 32'h8;
        start_run(2'd2, $urandom);
        wait_done(0, cyc);
        chk("stk.cycles", 64'(cyc), 64'(257));
        chk("stk.fa", 64'(fa1), 64'(148));
        chk("stk.fe", 64'(fe1), 64'(37));
        chk("stk.fg", 64'(fg1), 64'(45));
        chk("stk.err", 64'(ec1), 64'(1));
        chk("stk.pass", 64'(pass1), 64'(0));
        st_en = 1'b0;

        // read-only dump of an all-zero memory
        preload(1'b0);
        start_run(2'd3, $urandom);
        wait_done(0, cyc);
        chk("dump.cycles", 64'(cyc), 64'(129));
        chk("dump.nwrites", 64'(wq.size()), 64'(0));
        chk("dump.sig", 64'(sig1), 64'(0));
        chk("dump.pass", 64'(pass1), 64'(1));

        // reset in the middle of the write phase, then a clean run
        start_run(2'd0, $urandom);
        repeat (50) @(posedge clk);
        #1;
        chk("mid.a", 64'(a1), 64'(200));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid.busy", 64'(busy1), 64'(0));
        chk("mid.we", 64'(we1), 64'(0));
        chk("mid.outs", 64'({a1, wd1, done1, pass1, fa1}), 64'(0));
        chk("mid.res", 64'({fe1, fg1} | 64'(ec1) | 64'(sig1)), 64'(0));
        rst = 1'b0;
        start_run(2'd0, $urandom);
        wait_done(0, cyc);
        chk("mid.cycles", 64'(cyc), 64'(257));
        chk("mid.pass", 64'(pass1), 64'(1));

        // reset and start in the same cycle: reset wins
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; mode = 2'd0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("rs.busy", 64'(busy1), 64'(0));

        // start pulsed while busy is ignored
        start_run(2'd1, $urandom);
        wait_done(60, cyc);
        chk("pulse.cycles", 64'(cyc), 64'(257));

        // memory drops writes: checkerboard with seed bit 0 set
        drop = 1'b1;
        start_run(2'd1, 32'h1);
        wait_done(0, cyc);
        chk("sat.err4", 64'(ec2), 64'(15));
        chk("sat.fa4", 64'(fa2), 64'(4));
        chk("sat.pass4", 64'(pass2), 64'(0));
        chk("sat.err16", 64'(ec1), 64'(64));
        drop = 1'b0;

        // randomized runs with random faults
        for (int r = 0; r < 14; r++) begin
            drop  = ($urandom_range(0, 7) == 0);
            st_en = 1'($urandom_range(0, 1));
            st_w  = 7'($urandom);
            st_m  = 32'h1 << $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) preload(1'b1);
            m = $urandom_range(0, 3);
            start_run(2'(m), $urandom);
            wait_done($urandom_range(1, 250), cyc);
            chk("rnd.cycles", 64'(cyc), 64'((m == 3) ? 129 : 257));
        end
        drop = 1'b0; st_en = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
